// File: rtl/tod_pkg.sv
// Shared types and constants for the time-of-day minutes/hours stage.
// Mode encodings are visible on the mode output, so their values are fixed.
package tod_pkg;

    typedef enum logic [2:0] {
        RUN        = 3'd0,
        SET_HR     = 3'd1,
        SET_MIN    = 3'd2,
        SET_AL_HR  = 3'd3,
        SET_AL_MIN = 3'd4
    } mode_t;

    localparam int MIN_MOD = 60;
    localparam int DIGIT_W = 4;
    localparam int MIN_W   = 7;   // {tens[2:0], ones[3:0]}
    localparam int HR_W    = 6;   // {tens[1:0], ones[3:0]}

    function automatic logic [7:0] bcd_of(input int n);
        return {4'(n / 10), 4'(n % 10)};
    endfunction

    // Plain BCD increment without modulus handling.
    function automatic logic [7:0] bcd_step(input logic [7:0] v);
        if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        else
            return {v[7:4], v[3:0] + 4'd1};
    endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD modulo-MOD counter with synchronous clear and increment enable.
// Latency: value updates at the edge where inc is sampled; wrap is combinational.
// Backpressure: none, every inc is accepted.
module bcd_mod_counter
    import tod_pkg::*;
#(
    parameter int MOD = 60,
    parameter int W   = 7
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] value,
    output logic         wrap
);

    localparam int         TW   = W - DIGIT_W;
    localparam logic [7:0] LAST = bcd_of(MOD - 1);

    logic [TW-1:0]      tens;
    logic [DIGIT_W-1:0] ones;

    assign tens = value[W-1:DIGIT_W];
    assign ones = value[DIGIT_W-1:0];
    assign wrap = inc && (value == LAST[W-1:0]);

    always_ff @(posedge clk) begin
        if (clr) begin
            value <= '0;
        end else if (inc) begin
            if (wrap)
                value <= '0;
            else if (ones == 4'd9)
                value <= {tens + TW'(1), 4'd0};
            else
                value <= {tens, ones + 4'd1};
        end
    end

endmodule

// File: rtl/tod_hm_counter.sv
// Time-of-day BCD minutes/hours driven by the seconds stage's clk_div60 level, with button set FSM.
// Latency: count and hour/day/alarm pulses update one edge after tick_in rises; alarm needs TOD_ALARM_EN.
// Backpressure: none; minute events arriving outside RUN are dropped.
module tod_hm_counter
    import tod_pkg::*;
#(
    parameter int HOUR_MOD = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick_in,
    input  logic             btn_mode,
    input  logic             btn_inc,
    output logic [MIN_W-1:0] min_bcd,
    output logic [HR_W-1:0]  hr_bcd,
    output logic [2:0]       mode,
    output logic             hour_tick,
    output logic             day_tick,
    output logic             alarm_hit
);

    mode_t mode_q;
    logic  tick_q;
    logic  armed;
    logic  tick_edge;
    logic  minute_evt;
    logic  run_evt;
    logic  set_inc;
    logic  min_inc;
    logic  hr_inc;
    logic  min_wrap;
    logic  hr_wrap;

    assign tick_edge  = tick_in & ~tick_q;
    // The seconds stage raises clk_div60 right out of reset; that first rise only arms.
    assign minute_evt = tick_edge & armed;
    assign run_evt    = minute_evt & (mode_q == RUN);
    assign set_inc    = btn_inc & ~btn_mode;

    assign min_inc = run_evt | ((mode_q == SET_MIN) & set_inc);
    assign hr_inc  = (run_evt & min_wrap) | ((mode_q == SET_HR) & set_inc);
    assign mode    = mode_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            tick_q <= 1'b0;
            armed  <= 1'b0;
        end else begin
            tick_q <= tick_in;
            if (tick_edge)
                armed <= 1'b1;
        end
    end

    bcd_mod_counter #(.MOD(MIN_MOD), .W(MIN_W)) u_min (
        .clk   (clk),
        .clr   (rst),
        .inc   (min_inc),
        .value (min_bcd),
        .wrap  (min_wrap)
    );

    bcd_mod_counter #(.MOD(HOUR_MOD), .W(HR_W)) u_hr (
        .clk   (clk),
        .clr   (rst),
        .inc   (hr_inc),
        .value (hr_bcd),
        .wrap  (hr_wrap)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q    <= RUN;
            hour_tick <= 1'b0;
            day_tick  <= 1'b0;
        end else begin
            hour_tick <= run_evt & min_wrap;
            day_tick  <= run_evt & min_wrap & hr_wrap;
            if (btn_mode) begin
                case (mode_q)
                    RUN:        mode_q <= SET_HR;
                    SET_HR:     mode_q <= SET_MIN;
`ifdef TOD_ALARM_EN
                    SET_MIN:    mode_q <= SET_AL_HR;
                    SET_AL_HR:  mode_q <= SET_AL_MIN;
                    SET_AL_MIN: mode_q <= RUN;
`else
                    SET_MIN:    mode_q <= RUN;
`endif
                    default:    mode_q <= RUN;
                endcase
            end
        end
    end

`ifdef TOD_ALARM_EN
    logic [MIN_W-1:0] al_min;
    logic [HR_W-1:0]  al_hr;
    logic             al_min_wrap;
    logic             al_hr_wrap;
    logic             alarm_valid;
    logic [7:0]       min_nxt;
    logic [7:0]       hr_nxt;

    bcd_mod_counter #(.MOD(MIN_MOD), .W(MIN_W)) u_al_min (
        .clk   (clk),
        .clr   (rst),
        .inc   ((mode_q == SET_AL_MIN) & set_inc),
        .value (al_min),
        .wrap  (al_min_wrap)
    );

    bcd_mod_counter #(.MOD(HOUR_MOD), .W(HR_W)) u_al_hr (
        .clk   (clk),
        .clr   (rst),
        .inc   ((mode_q == SET_AL_HR) & set_inc),
        .value (al_hr),
        .wrap  (al_hr_wrap)
    );

    // Time the counters hold after this edge, so the hit lines up with the updated count.
    always_comb begin
        min_nxt = min_wrap ? 8'd0 : bcd_step({1'b0, min_bcd});
        hr_nxt  = {2'b00, hr_bcd};
        if (min_wrap)
            hr_nxt = hr_wrap ? 8'd0 : bcd_step({2'b00, hr_bcd});
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            alarm_valid <= 1'b0;
            alarm_hit   <= 1'b0;
        end else begin
            if (btn_mode && (mode_q == SET_AL_MIN))
                alarm_valid <= 1'b1;
            alarm_hit <= run_evt & alarm_valid & ~al_min_wrap & ~al_hr_wrap
                       & (hr_nxt == {2'b00, al_hr}) & (min_nxt == {1'b0, al_min});
        end
    end
`else
    assign alarm_hit = 1'b0;
`endif

endmodule
